// File: rtl/fpu_regport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_regport_arbiter_pkg
// Brief    : Shared types and encodings for the FPU register-port arbiter.
// Revision : 1.0
// ============================================================================
package fpu_regport_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    typedef enum logic {
        REQ_IO = 1'b0,
        REQ_UC = 1'b1
    } req_e;

    typedef enum logic [1:0] {
        TGT_CTRL = 2'd0,
        TGT_STAT = 2'd1,
        TGT_CLR  = 2'd2,
        TGT_NONE = 2'd3
    } target_e;

    typedef struct packed {
        target_e tgt;
        logic    wr;
    } access_t;

    localparam logic [1:0] c_IO_CTRL = 2'd0;
    localparam logic [1:0] c_IO_STAT = 2'd1;
    localparam logic [1:0] c_IO_CLR  = 2'd2;
    localparam logic [1:0] c_IO_RSVD = 2'd3;

    localparam logic [1:0] c_UC_LDCW = 2'd0;
    localparam logic [1:0] c_UC_STCW = 2'd1;
    localparam logic [1:0] c_UC_STSW = 2'd2;
    localparam logic [1:0] c_UC_CLEX = 2'd3;

    localparam logic [15:0] c_RSVD_READ = 16'hFFFF;

    // Writes to the status word have nowhere to go, so they decode as no target.
    function automatic access_t decode_io(input logic [1:0] addr, input logic wr);
        access_t a;
        a.wr = wr;
        case (addr)
            c_IO_CTRL: a.tgt = TGT_CTRL;
            c_IO_STAT: a.tgt = wr ? TGT_NONE : TGT_STAT;
            c_IO_CLR:  a.tgt = TGT_CLR;
            default:   a.tgt = TGT_NONE;
        endcase
        return a;
    endfunction

    function automatic access_t decode_uc(input logic [1:0] op);
        access_t a;
        case (op)
            c_UC_LDCW: begin a.tgt = TGT_CTRL; a.wr = 1'b1; end
            c_UC_STCW: begin a.tgt = TGT_CTRL; a.wr = 1'b0; end
            c_UC_STSW: begin a.tgt = TGT_STAT; a.wr = 1'b0; end
            default:   begin a.tgt = TGT_CLR;  a.wr = 1'b1; end
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_regport_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : fpu_rr_arbiter2
// Brief    : Two-way round-robin grant between I/O bus and microcode port.
// Revision : 1.0
// ============================================================================
module fpu_rr_arbiter2
    import fpu_regport_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_io_i,
    input  logic req_uc_i,
    input  logic update_i,
    output logic valid_o,
    output req_e grant_o
);

    req_e last_q;

    always_comb begin
        valid_o = req_io_i | req_uc_i;
        if (req_io_i && req_uc_i) begin
            grant_o = (last_q == REQ_IO) ? REQ_UC : REQ_IO;
        end else if (req_uc_i) begin
            grant_o = REQ_UC;
        end else begin
            grant_o = REQ_IO;
        end
    end

    // Resetting to IO hands the first tie to microcode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= REQ_IO;
        end else if (update_i && valid_o) begin
            last_q <= grant_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_regport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_regport_arbiter
// Brief    : Shares FPU control/status registers between I/O bus and microcode.
// Revision : 1.0
// ============================================================================
module fpu_regport_arbiter
    import fpu_regport_arbiter_pkg::*;
#(
    parameter int WAIT_ON_BUSY   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cs,
    input  logic [1:0]  io_addr,
    input  logic        io_wr_en,
    input  logic [15:0] io_data_in,
    output logic [15:0] io_data_out,
    output logic        io_ack,
    input  logic        uc_req,
    input  logic [1:0]  uc_op,
    input  logic [15:0] uc_data_in,
    output logic [15:0] uc_data_out,
    output logic        uc_ack,
    output logic        ctrl_cs,
    output logic        ctrl_wr_en,
    output logic [15:0] ctrl_data,
    input  logic        ctrl_ack,
    input  logic [15:0] control_word,
    output logic        stat_cs,
    input  logic [15:0] stat_data,
    input  logic        stat_ack,
    input  logic        fpu_busy,
    output logic        clear_exceptions,
    output logic        timeout_error
);

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    req_e        grant_q;
    access_t     acc_q;
    logic [7:0]  busy_cnt_q;
    logic        io_ack_q, uc_ack_q, ctrl_cs_q, ctrl_wr_en_q, stat_cs_q;
    logic        clear_exc_q, timeout_q;
    logic [15:0] io_data_q, uc_data_q, ctrl_data_q;

    logic        w_arb_valid;
    req_e        w_arb_grant;
    access_t     w_new_acc;
    logic [15:0] w_new_wdata;
    req_e        w_done_grant;
    logic        w_to_done, w_to_wait, w_to_issue, w_rd_valid, w_timeout;
    logic [15:0] w_rdata;

    fpu_rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_io_i (io_cs),
        .req_uc_i (uc_req),
        .update_i (state_q == ST_IDLE),
        .valid_o  (w_arb_valid),
        .grant_o  (w_arb_grant)
    );

    always_comb begin
        w_new_acc   = (w_arb_grant == REQ_IO) ? decode_io(io_addr, io_wr_en) : decode_uc(uc_op);
        w_new_wdata = (w_arb_grant == REQ_IO) ? io_data_in : uc_data_in;
    end

    always_comb begin
        w_to_done    = 1'b0;
        w_to_wait    = 1'b0;
        w_to_issue   = 1'b0;
        w_rd_valid   = 1'b0;
        w_timeout    = 1'b0;
        w_rdata      = c_RSVD_READ;
        w_done_grant = (state_q == ST_IDLE) ? w_arb_grant : grant_q;
        case (state_q)
            ST_IDLE: w_to_done = w_arb_valid && (w_new_acc.tgt == TGT_CLR);
            ST_ISSUE: begin
                case (acc_q.tgt)
                    TGT_CTRL: begin
                        if (ctrl_ack) begin
                            w_to_done  = 1'b1;
                            w_rd_valid = !acc_q.wr;
                            w_rdata    = control_word;
                        end
                    end
                    TGT_STAT: begin
                        if ((WAIT_ON_BUSY != 0) && fpu_busy) begin
                            w_to_wait = 1'b1;
                        end else if (stat_ack) begin
                            w_to_done  = 1'b1;
                            w_rd_valid = 1'b1;
                            w_rdata    = stat_data;
                        end
                    end
                    default: begin
                        w_to_done  = 1'b1;
                        w_rd_valid = !acc_q.wr;
                    end
                endcase
            end
            ST_WAIT_BUSY: begin
                // Once idle, an already-present ack completes without an extra ISSUE cycle.
                if (!fpu_busy) begin
                    if (stat_ack) begin
                        w_to_done  = 1'b1;
                        w_rd_valid = 1'b1;
                        w_rdata    = stat_data;
                    end else begin
                        w_to_issue = 1'b1;
                    end
                end else if (busy_cnt_q == c_TIMEOUT_LAST) begin
                    w_to_done  = 1'b1;
                    w_rd_valid = 1'b1;
                    w_rdata    = stat_data;
                    w_timeout  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_IO;
            acc_q        <= '{tgt: TGT_NONE, wr: 1'b0};
            busy_cnt_q   <= '0;
            io_ack_q     <= 1'b0;
            uc_ack_q     <= 1'b0;
            ctrl_cs_q    <= 1'b0;
            ctrl_wr_en_q <= 1'b0;
            stat_cs_q    <= 1'b0;
            clear_exc_q  <= 1'b0;
            timeout_q    <= 1'b0;
            io_data_q    <= '0;
            uc_data_q    <= '0;
            ctrl_data_q  <= '0;
        end else begin
            io_ack_q    <= 1'b0;
            uc_ack_q    <= 1'b0;
            clear_exc_q <= 1'b0;
            timeout_q   <= 1'b0;
            if ((state_q == ST_IDLE) && w_arb_valid) begin
                grant_q <= w_arb_grant;
                acc_q   <= w_new_acc;
            end
            if (w_to_done) begin
                state_q      <= ST_DONE;
                ctrl_cs_q    <= 1'b0;
                ctrl_wr_en_q <= 1'b0;
                ctrl_data_q  <= '0;
                stat_cs_q    <= 1'b0;
                clear_exc_q  <= (state_q == ST_IDLE);
                timeout_q    <= w_timeout;
                if (w_done_grant == REQ_IO) begin
                    io_ack_q <= 1'b1;
                    if (w_rd_valid) io_data_q <= w_rdata;
                end else begin
                    uc_ack_q <= 1'b1;
                    if (w_rd_valid) uc_data_q <= w_rdata;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_arb_valid) begin
                            state_q      <= ST_ISSUE;
                            ctrl_cs_q    <= (w_new_acc.tgt == TGT_CTRL);
                            ctrl_wr_en_q <= (w_new_acc.tgt == TGT_CTRL) && w_new_acc.wr;
                            ctrl_data_q  <= w_new_wdata;
                            stat_cs_q    <= (w_new_acc.tgt == TGT_STAT);
                        end
                    end
                    ST_ISSUE: begin
                        if (w_to_wait) begin
                            state_q    <= ST_WAIT_BUSY;
                            busy_cnt_q <= '0;
                        end
                    end
                    ST_WAIT_BUSY: begin
                        if (w_to_issue) state_q <= ST_ISSUE;
                        else            busy_cnt_q <= busy_cnt_q + 8'd1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign io_data_out      = io_data_q;
    assign io_ack           = io_ack_q;
    assign uc_data_out      = uc_data_q;
    assign uc_ack           = uc_ack_q;
    assign ctrl_cs          = ctrl_cs_q;
    assign ctrl_wr_en       = ctrl_wr_en_q;
    assign ctrl_data        = ctrl_data_q;
    assign stat_cs          = stat_cs_q;
    assign clear_exceptions = clear_exc_q;
    assign timeout_error    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_regport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_regport_arbiter
// Brief    : Self-checking bench for fpu_regport_arbiter (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_fpu_regport_arbiter;

    logic        clk, reset;
    logic        io_cs, io_wr_en, io_ack;
    logic [1:0]  io_addr;
    logic [15:0] io_data_in, io_data_out;
    logic        uc_req, uc_ack;
    logic [1:0]  uc_op;
    logic [15:0] uc_data_in, uc_data_out;
    logic        ctrl_cs, ctrl_wr_en, ctrl_ack;
    logic [15:0] ctrl_data, control_word, stat_data;
    logic        stat_cs, stat_ack, fpu_busy, clear_exceptions, timeout_error;
    logic [15:0] cw_reg;

    int total = 0;
    int bad   = 0;
    int clr_cnt = 0;
    int tmo_cnt = 0;
    int cs_cnt  = 0;

    typedef struct {
        bit          is_io;
        logic [15:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          is_io;
        logic [1:0]  code;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] stat;
        logic [15:0] stat2;
        int          busy_from;
        int          busy_to;
        logic [15:0] exp;
        int          lat;
        int          clr;
        int          tmo;
        bit          no_cs;
    } vec_t;
    vec_t vt[15];

    fpu_regport_arbiter #(.WAIT_ON_BUSY(1), .TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .io_cs            (io_cs),
        .io_addr          (io_addr),
        .io_wr_en         (io_wr_en),
        .io_data_in       (io_data_in),
        .io_data_out      (io_data_out),
        .io_ack           (io_ack),
        .uc_req           (uc_req),
        .uc_op            (uc_op),
        .uc_data_in       (uc_data_in),
        .uc_data_out      (uc_data_out),
        .uc_ack           (uc_ack),
        .ctrl_cs          (ctrl_cs),
        .ctrl_wr_en       (ctrl_wr_en),
        .ctrl_data        (ctrl_data),
        .ctrl_ack         (ctrl_ack),
        .control_word     (control_word),
        .stat_cs          (stat_cs),
        .stat_data        (stat_data),
        .stat_ack         (stat_ack),
        .fpu_busy         (fpu_busy),
        .clear_exceptions (clear_exceptions),
        .timeout_error    (timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register models: immediate ack, control word stored on write.
    assign ctrl_ack     = ctrl_cs;
    assign stat_ack     = stat_cs;
    assign control_word = cw_reg;
    initial cw_reg = 16'h0000;
    always @(posedge clk) if (ctrl_cs && ctrl_wr_en) cw_reg <= ctrl_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clear_exceptions) clr_cnt++;
        if (timeout_error) tmo_cnt++;
        if (ctrl_cs || stat_cs) cs_cnt++;
        if (io_ack || uc_ack) begin
            if (sb_q.size() == 0) begin
                check("spurious_ack", {62'd0, io_ack, uc_ack}, 64'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("ack_owner", {62'd0, io_ack, uc_ack}, e.is_io ? 64'd2 : 64'd1);
                if (e.is_io) check("io_data_out", {48'd0, io_data_out}, {48'd0, e.data});
                else         check("uc_data_out", {48'd0, uc_data_out}, {48'd0, e.data});
            end
        end
    end

    task automatic push_exp(input bit is_io, input logic [15:0] data);
        sb_t e;
        e.is_io = is_io;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int lat, c0, t0, s0;
        bit got;
        @(negedge clk); #1;
        c0 = clr_cnt; t0 = tmo_cnt; s0 = cs_cnt;
        push_exp(v.is_io, v.exp);
        stat_data = v.stat;
        if (v.busy_from == 0) fpu_busy = 1'b1;
        if (v.is_io) begin
            io_cs = 1'b1; io_addr = v.code; io_wr_en = v.wr; io_data_in = v.wdata;
        end else begin
            uc_req = 1'b1; uc_op = v.code; uc_data_in = v.wdata;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == v.busy_from) fpu_busy = 1'b1;
            if (lat == v.busy_to)   fpu_busy = 1'b0;
            if (lat == 3)           stat_data = v.stat2;
            got = v.is_io ? io_ack : uc_ack;
        end
        io_cs = 1'b0; uc_req = 1'b0; fpu_busy = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        @(negedge clk); #1;
        check({tag, "_clear_pulses"}, 64'(clr_cnt - c0), 64'(v.clr));
        check({tag, "_timeout_pulses"}, 64'(tmo_cnt - t0), 64'(v.tmo));
        if (v.no_cs) check({tag, "_no_chip_select"}, 64'(cs_cnt - s0), 64'd0);
    endtask

    task automatic both_req(input bit io_first, input string tag);
        bit order[2];
        int idx, n;
        @(negedge clk); #1;
        if (io_first) begin push_exp(1'b1, cw_reg); push_exp(1'b0, cw_reg); end
        else          begin push_exp(1'b0, cw_reg); push_exp(1'b1, cw_reg); end
        io_cs = 1'b1; io_addr = 2'd0; io_wr_en = 1'b0;
        uc_req = 1'b1; uc_op = 2'd1;
        idx = 0;
        n = 0;
        while ((io_cs || uc_req) && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (uc_ack && idx < 2) begin order[idx] = 1'b0; idx++; uc_req = 1'b0; end
            if (io_ack && idx < 2) begin order[idx] = 1'b1; idx++; io_cs = 1'b0; end
        end
        io_cs = 1'b0; uc_req = 1'b0;
        check({tag, "_served"}, 64'(idx), 64'd2);
        if (idx == 2) begin
            check({tag, "_first_is_io"}, {63'd0, order[0]}, {63'd0, io_first});
            check({tag, "_second_is_io"}, {63'd0, order[1]}, {63'd0, !io_first});
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return {9'd0, io_data_out, io_ack, uc_data_out, uc_ack, ctrl_cs, ctrl_wr_en,
                ctrl_data, stat_cs, clear_exceptions, timeout_error};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // is_io code wr wdata stat stat2 bfrom bto exp lat clr tmo no_cs
        vt[0]  = '{1'b0, 2'd1, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'h0272, 2, 0, 0, 1'b0};
        vt[1]  = '{1'b1, 2'd0, 1'b1, 16'h137F, 16'h0000, 16'h0000, -1, -1, 16'h0000, 2, 0, 0, 1'b0};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'h137F, 2, 0, 0, 1'b0};
        vt[3]  = '{1'b1, 2'd1, 1'b0, 16'h0000, 16'h1234, 16'h1234, -1, -1, 16'h1234, 2, 0, 0, 1'b0};
        vt[4]  = '{1'b0, 2'd2, 1'b0, 16'h0000, 16'h5A5A, 16'h5A5A, -1, -1, 16'h5A5A, 2, 0, 0, 1'b0};
        vt[5]  = '{1'b1, 2'd1, 1'b1, 16'hDEAD, 16'h0000, 16'h0000, -1, -1, 16'h1234, 2, 0, 0, 1'b1};
        vt[6]  = '{1'b1, 2'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'hFFFF, 2, 0, 0, 1'b1};
        vt[7]  = '{1'b1, 2'd3, 1'b1, 16'h1111, 16'h0000, 16'h0000, -1, -1, 16'hFFFF, 2, 0, 0, 1'b1};
        vt[8]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'h137F, 2, 0, 0, 1'b0};
        vt[9]  = '{1'b1, 2'd2, 1'b1, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'h137F, 1, 1, 0, 1'b1};
        vt[10] = '{1'b0, 2'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'h5A5A, 1, 1, 0, 1'b1};
        vt[11] = '{1'b0, 2'd0, 1'b0, 16'h0360, 16'h0000, 16'h0000, -1, -1, 16'h5A5A, 2, 0, 0, 1'b0};
        vt[12] = '{1'b1, 2'd1, 1'b0, 16'h0000, 16'hABCD, 16'hABCD,  1,  6, 16'hABCD, 7, 0, 0, 1'b0};
        vt[13] = '{1'b1, 2'd1, 1'b0, 16'h0000, 16'h0BAD, 16'hC0DE,  0, 10, 16'hC0DE, 10, 0, 1, 1'b0};
        vt[14] = '{1'b1, 2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'h0360, 2, 0, 0, 1'b0};

        reset = 1'b1;
        io_cs = 1'b0; io_addr = 2'd0; io_wr_en = 1'b0; io_data_in = 16'h0;
        uc_req = 1'b0; uc_op = 2'd0; uc_data_in = 16'h0;
        stat_data = 16'h0; fpu_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs_during", all_outs(), 64'd0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs_after", all_outs(), 64'd0);

        // Load control word from microcode: ISSUE cycle then ack.
        @(negedge clk); #1;
        push_exp(1'b0, 16'h0000);
        uc_req = 1'b1; uc_op = 2'd0; uc_data_in = 16'h0272;
        @(posedge clk); #1;
        check("ldcw_issue_cs", {63'd0, ctrl_cs}, 64'd1);
        check("ldcw_issue_wr_en", {63'd0, ctrl_wr_en}, 64'd1);
        check("ldcw_issue_data", {48'd0, ctrl_data}, 64'h0272);
        check("ldcw_issue_no_ack", {63'd0, uc_ack}, 64'd0);
        @(posedge clk); #1;
        check("ldcw_ack_cycle3", {63'd0, uc_ack}, 64'd1);
        check("ldcw_done_cs_off", {63'd0, ctrl_cs}, 64'd0);
        uc_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            do_req(vt[i], $sformatf("vec%0d", i));
        end

        for (int r = 0; r < 4; r++) begin
            both_req(1'b0, $sformatf("tie%0d", r));
        end
        v = '{1'b0, 2'd1, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'h0360, 2, 0, 0, 1'b0};
        do_req(v, "uc_solo");
        both_req(1'b1, "tie_after_uc");

        // Reset in the middle of a busy-wait drops the transaction.
        @(negedge clk); #1;
        stat_data = 16'h7777;
        fpu_busy = 1'b1;
        io_cs = 1'b1; io_addr = 2'd1; io_wr_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("pre_reset_stat_cs", {63'd0, stat_cs}, 64'd1);
        #2 reset = 1'b1;
        #1 check("reset_mid_wait_outputs", all_outs(), 64'd0);
        io_cs = 1'b0; fpu_busy = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_no_pending_ack", 64'(sb_q.size()), 64'd0);
        v = '{1'b1, 2'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, -1, 16'hFFFF, 2, 0, 0, 1'b1};
        do_req(v, "rsvd_after_reset");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_regport_arbiter.md
Name: fpu_regport_arbiter

Overview:
Shares the FPU control-word and status-word register pair between two requesters: the CPU I/O bus (port accesses) and the microcode FPU-instruction port (FLDCW/FSTCW/FSTSW/FCLEX).
- Arbitrates round-robin between the two requesters.
- Sequences the register chip-selects and write enables.
- Optionally stalls status reads until the FPU core is idle, bounded by a timeout.
- Returns data with a single-cycle acknowledge to the winning requester.
Sits between the bus/microcode front end and the control/status register instances.

Parameters:
WAIT_ON_BUSY, 1, when 1 a status read waits for fpu_busy=0 before sampling.
TIMEOUT_CYCLES, 64, maximum busy-wait cycles before forced completion (range 1..255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
io_cs  in  1  CPU I/O request; held until io_ack
io_addr  in  2  0=control word, 1=status word, 2=clear exceptions, 3=reserved
io_wr_en  in  1  1=write, 0=read
io_data_in  in  16  I/O write data
io_data_out  out  16  I/O read data, valid with io_ack
io_ack  out  1  one-cycle completion pulse
uc_req  in  1  microcode request; held until uc_ack
uc_op  in  2  0=load CW, 1=store CW, 2=store SW, 3=clear exceptions
uc_data_in  in  16  load-CW data
uc_data_out  out  16  store data, valid with uc_ack
uc_ack  out  1  one-cycle completion pulse
ctrl_cs  out  1  control-register chip select
ctrl_wr_en  out  1  control-register write enable
ctrl_data  out  16  control-register write data
ctrl_ack  in  1  control-register acknowledge
control_word  in  16  current control word
stat_cs  out  1  status-register chip select
stat_data  in  16  status-register read data
stat_ack  in  1  status-register acknowledge
fpu_busy  in  1  FPU core executing
clear_exceptions  out  1  one-cycle pulse to FPU core
timeout_error  out  1  one-cycle pulse on busy-wait timeout

Behaviour:
Reset:
- All outputs 0.
- State IDLE.
- last_grant = IO, so microcode wins the first tie.
- Reset mid-operation drops the transaction: no ack, no pulse. Requesters re-issue.

IDLE:
- Grant goes to the single active requester. If both are active, grant goes to the one not granted last.
- Latch the grant, the operation and the write data; update last_grant.
- Next state: ISSUE. Operations 2 (io) and 3 (uc) go to DONE instead, with clear_exceptions pulsed that cycle.

ISSUE:
- Control accesses: assert ctrl_cs; ctrl_wr_en=1 for writes; ctrl_data = latched data.
- Status accesses: assert stat_cs.
- Stay in ISSUE while the matching ack is 0. On ack=1, capture read data and go to DONE.
- Control reads return control_word.
- Status read with WAIT_ON_BUSY=1 and fpu_busy=1: go to WAIT_BUSY without sampling.

WAIT_BUSY:
- stat_cs held; counter increments each cycle.
- fpu_busy=0: return to sampling; wait for stat_ack, then DONE.
- Counter reaches TIMEOUT_CYCLES: sample stat_data, pulse timeout_error, go to DONE.

DONE:
- Pulse the ack of the granted requester for one cycle with data_out valid.
- All chip selects deasserted.
- Next state: IDLE.
- A requester still asserted in the cycle after DONE is treated as a new request.

Boundary cases:
- I/O write to addr 1 (status): ignored, acked through DONE, no chip select.
- I/O access to addr 3: reads return 16'hFFFF, writes are dropped, both acked.
- data_out holds its value until the next ack.
- Minimum latency, request to ack: 3 cycles (IDLE, ISSUE, DONE) when the register acks immediately; 2 cycles for clear-exceptions.
- A request arriving while not in IDLE waits; no queue depth beyond the held request.

Decomposition:
- Shared package: state enum (IDLE, ISSUE, WAIT_BUSY, DONE), requester id (IO, UC), uc_op/io_addr encodings, reserved read value 16'hFFFF.
- One sub-module: fpu_rr_arbiter2, a 2-way round-robin grant with last-grant register.

Test Plan:
- After reset, uc_req op0 data 16'h0272 with ctrl_ack tied to ctrl_cs -> ctrl_wr_en/ctrl_data=16'h0272 in the ISSUE cycle, uc_ack on cycle 3.
- io_cs and uc_req asserted in the same cycle, repeated 4 times -> grants alternate UC, IO, UC, IO.
- io read addr1, stat_data=16'hABCD, fpu_busy high for 5 cycles -> io_ack 5 cycles later than the unstalled case, io_data_out=16'hABCD.
- fpu_busy stuck high, TIMEOUT_CYCLES=8 -> timeout_error pulses once, io_ack follows with current stat_data.
- io addr2 write, then uc op3 -> exactly one clear_exceptions pulse per request, acks at 2-cycle latency.
- reset asserted while in WAIT_BUSY -> all outputs 0 immediately; io addr3 read afterward returns 16'hFFFF.
